// File: rtl/alu_rsv_station.sv
// ALU reservation station: dual-slot dispatch write, two-CDB operand capture
// (including same-cycle bypass), lowest-index-first issue over valid/ready.
module alu_rsv_station #(
    parameter int ENT_NUM  = 8,
    parameter int ENT_SEL  = 3,
    parameter int DATA_LEN = 32,
    parameter int TAG_LEN  = 6,
    parameter int PAY_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                we1,
    input  logic                we2,
    input  logic [ENT_SEL-1:0]  waddr1,
    input  logic [ENT_SEL-1:0]  waddr2,
    input  logic                src1_v1,
    input  logic                src2_v1,
    input  logic [DATA_LEN-1:0] src1_d1,
    input  logic [DATA_LEN-1:0] src2_d1,
    input  logic [TAG_LEN-1:0]  src1_t1,
    input  logic [TAG_LEN-1:0]  src2_t1,
    input  logic [PAY_LEN-1:0]  pay_1,
    input  logic                src1_v2,
    input  logic                src2_v2,
    input  logic [DATA_LEN-1:0] src1_d2,
    input  logic [DATA_LEN-1:0] src2_d2,
    input  logic [TAG_LEN-1:0]  src1_t2,
    input  logic [TAG_LEN-1:0]  src2_t2,
    input  logic [PAY_LEN-1:0]  pay_2,
    input  logic                cdb0_en,
    input  logic [TAG_LEN-1:0]  cdb0_tag,
    input  logic [DATA_LEN-1:0] cdb0_dat,
    input  logic                cdb1_en,
    input  logic [TAG_LEN-1:0]  cdb1_tag,
    input  logic [DATA_LEN-1:0] cdb1_dat,
    output logic [ENT_NUM-1:0]  busy,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [ENT_SEL-1:0]  iss_addr,
    output logic [DATA_LEN-1:0] iss_op1,
    output logic [DATA_LEN-1:0] iss_op2,
    output logic [PAY_LEN-1:0]  iss_pay
);

    logic [ENT_NUM-1:0]  busy_q;
    logic [ENT_NUM-1:0]  v1_q;
    logic [ENT_NUM-1:0]  v2_q;
    logic [DATA_LEN-1:0] d1_q  [ENT_NUM];
    logic [DATA_LEN-1:0] d2_q  [ENT_NUM];
    logic [TAG_LEN-1:0]  t1_q  [ENT_NUM];
    logic [TAG_LEN-1:0]  t2_q  [ENT_NUM];
    logic [PAY_LEN-1:0]  pay_q [ENT_NUM];
    logic [ENT_NUM-1:0]  ready;
    logic                issue_fire;

    // Operand capture: keep a valid operand, otherwise snoop the CDBs (cdb0 has priority).
    // Returns {valid, data}; used both for dispatch bypass and for wakeup.
    function automatic logic [DATA_LEN:0] capture(input logic v,
                                                  input logic [DATA_LEN-1:0] d,
                                                  input logic [TAG_LEN-1:0] t);
        if (v) return {1'b1, d};
        if (cdb0_en && cdb0_tag == t) return {1'b1, cdb0_dat};
        if (cdb1_en && cdb1_tag == t) return {1'b1, cdb1_dat};
        return {1'b0, d};
    endfunction

    assign busy       = busy_q;
    assign ready      = busy_q & v1_q & v2_q;
    assign issue_fire = iss_valid & iss_ready;

    // Entry state: flush beats everything; otherwise wakeup, then issue-clear, then
    // dispatch writes (slot 2 last) so a write to the issuing entry keeps it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            v1_q   <= '0;
            v2_q   <= '0;
            for (int e = 0; e < ENT_NUM; e++) begin
                d1_q[e]  <= '0;
                d2_q[e]  <= '0;
                t1_q[e]  <= '0;
                t2_q[e]  <= '0;
                pay_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < ENT_NUM; e++) begin
                if (flush) begin
                    busy_q[e] <= 1'b0;
                end else begin
                    if (busy_q[e]) begin
                        {v1_q[e], d1_q[e]} <= capture(v1_q[e], d1_q[e], t1_q[e]);
                        {v2_q[e], d2_q[e]} <= capture(v2_q[e], d2_q[e], t2_q[e]);
                    end
                    if (issue_fire && iss_addr == ENT_SEL'(e)) begin
                        busy_q[e] <= 1'b0;
                    end
                    if (we1 && waddr1 == ENT_SEL'(e)) begin
                        busy_q[e]          <= 1'b1;
                        {v1_q[e], d1_q[e]} <= capture(src1_v1, src1_d1, src1_t1);
                        {v2_q[e], d2_q[e]} <= capture(src2_v1, src2_d1, src2_t1);
                        t1_q[e]            <= src1_t1;
                        t2_q[e]            <= src2_t1;
                        pay_q[e]           <= pay_1;
                    end
                    if (we2 && waddr2 == ENT_SEL'(e)) begin
                        busy_q[e]          <= 1'b1;
                        {v1_q[e], d1_q[e]} <= capture(src1_v2, src1_d2, src1_t2);
                        {v2_q[e], d2_q[e]} <= capture(src2_v2, src2_d2, src2_t2);
                        t1_q[e]            <= src1_t2;
                        t2_q[e]            <= src2_t2;
                        pay_q[e]           <= pay_2;
                    end
                end
            end
        end
    end

    // Select the lowest-index ready entry; all offer fields read zero when none is ready.
    always_comb begin
        iss_valid = 1'b0;
        iss_addr  = '0;
        iss_op1   = '0;
        iss_op2   = '0;
        iss_pay   = '0;
        for (int e = ENT_NUM - 1; e >= 0; e--) begin
            if (ready[e]) begin
                iss_valid = 1'b1;
                iss_addr  = ENT_SEL'(e);
                iss_op1   = d1_q[e];
                iss_op2   = d2_q[e];
                iss_pay   = pay_q[e];
            end
        end
    end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Testbench for alu_rsv_station: directed vector table, reset sequence,
// then randomized traffic against an entry-level reference model.
module tb_alu_rsv_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        we1, we2;
    logic [2:0]  waddr1, waddr2;
    logic        src1_v1, src2_v1, src1_v2, src2_v2;
    logic [31:0] src1_d1, src2_d1, src1_d2, src2_d2;
    logic [5:0]  src1_t1, src2_t1, src1_t2, src2_t2;
    logic [15:0] pay_1, pay_2;
    logic        cdb0_en, cdb1_en;
    logic [5:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_dat, cdb1_dat;
    logic [7:0]  busy;
    logic        iss_valid, iss_ready;
    logic [2:0]  iss_addr;
    logic [31:0] iss_op1, iss_op2;
    logic [15:0] iss_pay;

    int n_chk  = 0;
    int n_fail = 0;

    alu_rsv_station dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .src1_v1(src1_v1), .src2_v1(src2_v1), .src1_d1(src1_d1), .src2_d1(src2_d1),
        .src1_t1(src1_t1), .src2_t1(src2_t1), .pay_1(pay_1),
        .src1_v2(src1_v2), .src2_v2(src2_v2), .src1_d2(src1_d2), .src2_d2(src2_d2),
        .src1_t2(src1_t2), .src2_t2(src2_t2), .pay_2(pay_2),
        .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_dat(cdb0_dat),
        .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_dat(cdb1_dat),
        .busy(busy), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
        .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_pay(iss_pay)
    );

    always #5 clk = ~clk;

    // Directed vector: slot 1 fully controllable, slot 2 always carries two valid operands.
    typedef struct packed {
        logic w1; logic [2:0] a1; logic av, bv; logic [31:0] ad, bd; logic [5:0] at, bt;
        logic w2; logic [2:0] a2; logic [31:0] ad2, bd2;
        logic c0; logic [5:0] c0t; logic [31:0] c0d;
        logic c1; logic [5:0] c1t; logic [31:0] c1d;
        logic rdy, fl;
        logic [7:0] eb; logic ev; logic [2:0] ea; logic [31:0] e1, e2;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic busy, v1, v2;
        logic [31:0] d1, d2;
        logic [5:0] t1, t2;
        logic [15:0] pay;
    } ent_t;

    ent_t m[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        flush = 0; we1 = 0; we2 = 0; waddr1 = 0; waddr2 = 0;
        src1_v1 = 0; src2_v1 = 0; src1_d1 = 0; src2_d1 = 0; src1_t1 = 0; src2_t1 = 0; pay_1 = 0;
        src1_v2 = 0; src2_v2 = 0; src1_d2 = 0; src2_d2 = 0; src1_t2 = 0; src2_t2 = 0; pay_2 = 0;
        cdb0_en = 0; cdb0_tag = 0; cdb0_dat = 0; cdb1_en = 0; cdb1_tag = 0; cdb1_dat = 0;
        iss_ready = 0;
    endtask

    function automatic vec_t wr1(input logic [2:0] a, input logic [31:0] ad, input logic [31:0] bd);
        vec_t v = '0;
        v.w1 = 1; v.a1 = a; v.av = 1; v.bv = 1; v.ad = ad; v.bd = bd;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic [7:0] eb, input logic ev, input logic [2:0] ea,
                       input logic [31:0] e1, input logic [31:0] e2);
        v.eb = eb; v.ev = ev; v.ea = ea; v.e1 = e1; v.e2 = e2;
        tbl.push_back(v);
    endtask

    // Protocol watch: no duplicate slot targets, no write to an occupied entry unless it issues now.
    always @(posedge clk) begin
        if (rst_n && !flush && (we1 || we2)) begin
            n_chk++;
            if ((we1 && we2 && waddr1 == waddr2) ||
                (we1 && busy[waddr1] && !(iss_valid && iss_ready && iss_addr == waddr1)) ||
                (we2 && busy[waddr2] && !(iss_valid && iss_ready && iss_addr == waddr2))) begin
                n_fail++;
                $display("FAIL protocol: we=%b%b waddr=%0d/%0d busy=%h", we1, we2, waddr1, waddr2, busy);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_sel();
        for (int i = 0; i < 8; i++)
            if (m[i].busy && m[i].v1 && m[i].v2) return i;
        return -1;
    endfunction

    function automatic logic [32:0] byp(input logic v, input logic [31:0] d, input logic [5:0] t);
        if (v) return {1'b1, d};
        if (cdb0_en && cdb0_tag == t) return {1'b1, cdb0_dat};
        if (cdb1_en && cdb1_tag == t) return {1'b1, cdb1_dat};
        return {1'b0, d};
    endfunction

    task automatic model_write(input int a, input logic va, input logic [31:0] da, input logic [5:0] ta,
                               input logic vb, input logic [31:0] db, input logic [5:0] tb,
                               input logic [15:0] p);
        m[a].busy = 1;
        {m[a].v1, m[a].d1} = byp(va, da, ta);
        {m[a].v2, m[a].d2} = byp(vb, db, tb);
        m[a].t1 = ta; m[a].t2 = tb; m[a].pay = p;
    endtask

    task automatic model_edge();
        int sel;
        sel = model_sel();
        if (flush) begin
            for (int i = 0; i < 8; i++) m[i].busy = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (m[i].busy) begin
                    {m[i].v1, m[i].d1} = byp(m[i].v1, m[i].d1, m[i].t1);
                    {m[i].v2, m[i].d2} = byp(m[i].v2, m[i].d2, m[i].t2);
                end
            if (sel >= 0 && iss_ready) m[sel].busy = 0;
            if (we1) model_write(int'(waddr1), src1_v1, src1_d1, src1_t1, src2_v1, src2_d1, src2_t1, pay_1);
            if (we2) model_write(int'(waddr2), src1_v2, src1_d2, src1_t2, src2_v2, src2_d2, src2_t2, pay_2);
        end
    endtask

    task automatic model_check();
        int sel;
        logic [7:0] eb;
        logic [83:0] exp_off;
        sel = model_sel();
        for (int i = 0; i < 8; i++) eb[i] = m[i].busy;
        exp_off = (sel >= 0) ? {1'b1, 3'(sel), m[sel].d1, m[sel].d2, m[sel].pay} : '0;
        chk("rnd_busy", busy, eb);
        chk("rnd_offer", {iss_valid, iss_addr, iss_op1, iss_op2, iss_pay}, exp_off);
    endtask

    task automatic rnd_inputs();
        int fr[$];
        int k;
        idle();
        for (int i = 0; i < 8; i++) if (!m[i].busy) fr.push_back(i);
        flush     = ($urandom_range(0, 39) == 0);
        iss_ready = ($urandom_range(0, 3) != 0);
        if (fr.size() > 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, fr.size() - 1);
            we1 = 1; waddr1 = 3'(fr[k]); fr.delete(k);
        end
        if (fr.size() > 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, fr.size() - 1);
            we2 = 1; waddr2 = 3'(fr[k]); fr.delete(k);
        end
        src1_v1 = ($urandom_range(0, 2) != 0); src1_d1 = $urandom; src1_t1 = 6'($urandom_range(0, 7));
        src2_v1 = ($urandom_range(0, 2) != 0); src2_d1 = $urandom; src2_t1 = 6'($urandom_range(0, 7));
        src1_v2 = ($urandom_range(0, 2) != 0); src1_d2 = $urandom; src1_t2 = 6'($urandom_range(0, 7));
        src2_v2 = ($urandom_range(0, 2) != 0); src2_d2 = $urandom; src2_t2 = 6'($urandom_range(0, 7));
        pay_1 = 16'($urandom); pay_2 = 16'($urandom);
        cdb0_en = ($urandom_range(0, 1) == 1); cdb0_tag = 6'($urandom_range(0, 7)); cdb0_dat = $urandom;
        cdb1_en = ($urandom_range(0, 1) == 1); cdb1_tag = 6'($urandom_range(0, 7)); cdb1_dat = $urandom;
    endtask

    initial begin
        vec_t v;
        idle();
        rst_n = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 8'h00);
        chk("reset_offer", {iss_valid, iss_addr, iss_op1, iss_op2, iss_pay}, 84'h0);
        rst_n = 1;
        @(negedge clk);

        // Dual write to 2 and 5, issued in index order
        v = wr1(3'd2, 32'h11, 32'h12); v.w2 = 1; v.a2 = 3'd5; v.ad2 = 32'h51; v.bd2 = 32'h52; v.rdy = 1;
        add(v, 8'h24, 1, 3'd2, 32'h11, 32'h12);
        v = '0; v.rdy = 1; add(v, 8'h20, 1, 3'd5, 32'h51, 32'h52);
        v = '0; v.rdy = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        // Pending src1 tag 9 woken by cdb0
        v = '0; v.w1 = 1; v.a1 = 3'd0; v.at = 6'd9; v.bv = 1; v.bd = 32'h33; v.rdy = 1;
        add(v, 8'h01, 0, 3'd0, 32'h0, 32'h0);
        v = '0; v.c0 = 1; v.c0t = 6'd5; v.c0d = 32'h1; v.rdy = 1; add(v, 8'h01, 0, 3'd0, 32'h0, 32'h0);
        v = '0; v.c0 = 1; v.c0t = 6'd9; v.c0d = 32'hDEAD; add(v, 8'h01, 1, 3'd0, 32'hDEAD, 32'h33);
        v = '0; v.rdy = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        // Same-cycle bypass from cdb1 into src2
        v = '0; v.w1 = 1; v.a1 = 3'd3; v.av = 1; v.ad = 32'h44; v.bt = 6'd3;
        v.c1 = 1; v.c1t = 6'd3; v.c1d = 32'd7; add(v, 8'h08, 1, 3'd3, 32'h44, 32'd7);
        v = '0; v.rdy = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        // Both CDBs match the same tag: cdb0 wins
        v = '0; v.w1 = 1; v.a1 = 3'd7; v.at = 6'd12; v.bv = 1; v.bd = 32'h1;
        add(v, 8'h80, 0, 3'd0, 32'h0, 32'h0);
        v = '0; v.c0 = 1; v.c0t = 6'd12; v.c0d = 32'hAA; v.c1 = 1; v.c1t = 6'd12; v.c1d = 32'hBB;
        add(v, 8'h80, 1, 3'd7, 32'hAA, 32'h1);
        v = '0; v.rdy = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        // Backpressure: 1 and 4 ready, held 3 cycles, then drained in order
        v = wr1(3'd4, 32'h4, 32'h40); v.w2 = 1; v.a2 = 3'd1; v.ad2 = 32'h1; v.bd2 = 32'h10;
        add(v, 8'h12, 1, 3'd1, 32'h1, 32'h10);
        for (int i = 0; i < 3; i++) begin v = '0; add(v, 8'h12, 1, 3'd1, 32'h1, 32'h10); end
        v = '0; v.rdy = 1; add(v, 8'h10, 1, 3'd4, 32'h4, 32'h40);
        v = '0; v.rdy = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        // Issue and rewrite the same entry at one edge: write wins
        v = wr1(3'd2, 32'h21, 32'h22); add(v, 8'h04, 1, 3'd2, 32'h21, 32'h22);
        v = wr1(3'd2, 32'h23, 32'h24); v.rdy = 1; add(v, 8'h04, 1, 3'd2, 32'h23, 32'h24);
        v = '0; v.rdy = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        // Flush with a same-edge write to 6 and a pending issue of 3
        v = wr1(3'd3, 32'h31, 32'h32); add(v, 8'h08, 1, 3'd3, 32'h31, 32'h32);
        v = wr1(3'd6, 32'h61, 32'h62); v.rdy = 1; v.fl = 1; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);
        v = '0; add(v, 8'h00, 0, 3'd0, 32'h0, 32'h0);

        foreach (tbl[i]) begin
            v = tbl[i];
            idle();
            we1 = v.w1; waddr1 = v.a1;
            src1_v1 = v.av; src1_d1 = v.ad; src1_t1 = v.at;
            src2_v1 = v.bv; src2_d1 = v.bd; src2_t1 = v.bt; pay_1 = 16'h0001;
            we2 = v.w2; waddr2 = v.a2;
            src1_v2 = 1; src1_d2 = v.ad2; src2_v2 = 1; src2_d2 = v.bd2; pay_2 = 16'h0002;
            cdb0_en = v.c0; cdb0_tag = v.c0t; cdb0_dat = v.c0d;
            cdb1_en = v.c1; cdb1_tag = v.c1t; cdb1_dat = v.c1d;
            iss_ready = v.rdy; flush = v.fl;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, v.eb);
            chk($sformatf("vec%0d_valid", i), iss_valid, v.ev);
            chk($sformatf("vec%0d_addr", i), iss_addr, v.ea);
            chk($sformatf("vec%0d_op1", i), iss_op1, v.e1);
            chk($sformatf("vec%0d_op2", i), iss_op2, v.e2);
        end

        // Asynchronous reset mid-stream
        idle();
        we1 = 1; waddr1 = 3'd1; src1_v1 = 1; src2_v1 = 1; src1_d1 = 32'h5;
        we2 = 1; waddr2 = 3'd2; src1_v2 = 1; src2_v2 = 1;
        @(posedge clk);
        @(negedge clk);
        idle();
        chk("pre_reset_busy", busy, 8'h06);
        #2 rst_n = 0;
        #1;
        chk("async_reset_busy", busy, 8'h00);
        chk("async_reset_valid", iss_valid, 1'b0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", busy, 8'h00);
        chk("post_reset_offer", {iss_valid, iss_addr, iss_op1, iss_op2, iss_pay}, 84'h0);

        // Randomized traffic against the model (DUT is empty here)
        for (int i = 0; i < 8; i++) m[i] = '{default: '0};
        for (int c = 0; c < 600; c++) begin
            rnd_inputs();
            @(posedge clk);
            model_edge();
            @(negedge clk);
            model_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
